// File: rtl/mul_shiftadd_acc.sv
// mul_shiftadd_acc: sequential shift-add multiply-accumulate.
// product = multiplicand * multiplier + addend, one multiplier bit per cycle.
// Used as the functional inverse of the subtract-shift divider
// (quotient * divisor + remainder rebuilds the dividend).
//
// Optional build macro: MUL_SHIFTADD_SIGNED_EN
//   undefined : unsigned operands, product taken straight from the accumulator
//   defined   : two's complement operands; magnitudes are multiplied, then the
//               sign is applied and the addend is added in a final registered step
//
// phase | meaning
// ------+-------------------------------------------------------------
// LOAD  | pc == 0: sample operands, seed accumulator, pc <= 1
// STEP  | pc == 1..DATA_W: conditional add of mcand into hi, shift acc right
// DONE  | pc == DATA_W+1: done <= 1, result held while en stays high
//
// en low in any phase clears pc, accumulator and done on the next edge.

module mul_shiftadd_acc #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  done,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    input  logic [DATA_W-1:0]     addend,
    output logic [2*DATA_W-1:0]   product
);

    localparam int PC_W = $clog2(DATA_W + 5) + 1;
    localparam logic [PC_W-1:0] PC_ONE       = PC_W'(1);
    localparam logic [PC_W-1:0] PC_STEP_LAST = PC_W'(DATA_W);

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_STEP,
        PH_DONE
    } phase_t;

    phase_t phase;

    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W:0]   hi_q,    hi_d;
    logic [DATA_W-1:0] lo_q,    lo_d;
    logic              done_q,  done_d;
    logic [DATA_W:0]   sum;

`ifdef MUL_SHIFTADD_SIGNED_EN
    logic                neg_q,    neg_d;
    logic [DATA_W-1:0]   addend_q, addend_d;
    logic [2*DATA_W-1:0] prod_q,   prod_d;
    logic [2*DATA_W-1:0] mag_prod;
    logic [2*DATA_W-1:0] signed_prod;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;

    // Operand magnitudes; the most negative value maps to 2^(N-1) unsigned.
    always_comb begin
        abs_a = multiplicand[DATA_W-1] ? (~multiplicand + 1'b1) : multiplicand;
        abs_b = multiplier[DATA_W-1]   ? (~multiplier + 1'b1)   : multiplier;
    end
`endif

    // Phase decode from the step counter.
    always_comb begin
        phase = PH_DONE;
        if (pc_q == '0) begin
            phase = PH_LOAD;
        end else if (pc_q <= PC_STEP_LAST) begin
            phase = PH_STEP;
        end
    end

    // Shift-add datapath and next-state selection.
    always_comb begin
        pc_d    = pc_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = done_q;
        sum     = hi_q + (lo_q[0] ? {1'b0, mcand_q} : '0);
`ifdef MUL_SHIFTADD_SIGNED_EN
        neg_d       = neg_q;
        addend_d    = addend_q;
        prod_d      = prod_q;
        mag_prod    = {hi_q[DATA_W-1:0], lo_q};
        signed_prod = neg_q ? (~mag_prod + 1'b1) : mag_prod;
`endif
        if (!en) begin
            pc_d    = '0;
            mcand_d = '0;
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b0;
`ifdef MUL_SHIFTADD_SIGNED_EN
            neg_d    = 1'b0;
            addend_d = '0;
            prod_d   = '0;
`endif
        end else begin
            case (phase)
                PH_LOAD: begin
`ifdef MUL_SHIFTADD_SIGNED_EN
                    mcand_d  = abs_a;
                    lo_d     = abs_b;
                    hi_d     = '0;
                    neg_d    = multiplicand[DATA_W-1] ^ multiplier[DATA_W-1];
                    addend_d = addend;
`else
                    mcand_d = multiplicand;
                    lo_d    = multiplier;
                    hi_d    = {1'b0, addend};
`endif
                    pc_d = PC_ONE;
                end
                PH_STEP: begin
                    // Logical right shift of the whole accumulator with sum in hi;
                    // the carry bit of hi is always shifted back to zero.
                    {hi_d, lo_d} = {1'b0, sum, lo_q[DATA_W-1:1]};
                    pc_d         = pc_q + PC_ONE;
                end
                PH_DONE: begin
                    done_d = 1'b1;
`ifdef MUL_SHIFTADD_SIGNED_EN
                    prod_d = signed_prod + {{DATA_W{addend_q[DATA_W-1]}}, addend_q};
`endif
                end
                default: begin
                    pc_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MUL_SHIFTADD_SIGNED_EN
            neg_q    <= 1'b0;
            addend_q <= '0;
            prod_q   <= '0;
`endif
        end else begin
            pc_q    <= pc_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MUL_SHIFTADD_SIGNED_EN
            neg_q    <= neg_d;
            addend_q <= addend_d;
            prod_q   <= prod_d;
`endif
        end
    end

    assign done = done_q;
`ifdef MUL_SHIFTADD_SIGNED_EN
    assign product = prod_q;
`else
    assign product = {hi_q[DATA_W-1:0], lo_q};
`endif

endmodule

// File: doc/mul_shiftadd_acc.md
Name: mul_shiftadd_acc

Overview:
Sequential shift-add multiply-accumulate. Computes product = multiplicand * multiplier + addend, one multiplier bit per cycle. It rebuilds a dividend from the quotient, divisor and remainder produced by the subtract-shift divider, and is used as the divider's functional inverse and as a general low-area multiplier. Its en/done protocol is identical to the divider's.

Parameters:
DATA_W, 32, operand width; product is 2*DATA_W bits.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
en  input  1  level enable; high runs/holds an operation, low clears the block
done  output  1  result valid; registered
multiplicand  input  DATA_W  operand A, sampled at pc=0
multiplier  input  DATA_W  operand B, sampled at pc=0
addend  input  DATA_W  operand C, sampled at pc=0
product  output  2*DATA_W  A*B+C; valid while done=1

Behaviour:
- Reset is asynchronous and active-high on rst. Clock is clk. On rst: pc=0, accumulator=0, done=0, product=0.
- State:
  - pc counter, width $clog2(DATA_W+5)+1.
  - mcand_reg[DATA_W-1:0].
  - acc = {hi[DATA_W:0], lo[DATA_W-1:0]}.
  - product = {hi[DATA_W-1:0], lo}.
- en=1, pc=0 (LOAD):
  - mcand_reg <= multiplicand; lo <= multiplier; hi <= {1'b0, addend}.
  - pc <= 1.
- en=1, pc=1..DATA_W (STEP):
  - sum = hi + (lo[0] ? {1'b0, mcand_reg} : 0), DATA_W+1 bits.
  - acc <= {1'b0, sum, lo[DATA_W-1:1]}, i.e. logical right shift by one with sum in hi.
  - pc <= pc+1.
- en=1, pc=DATA_W+1 (DONE):
  - done <= 1; pc, acc and product hold.
  - Holds for as long as en stays high.
- en=0, any state: synchronously pc <= 0, acc <= 0, done <= 0. A new operation starts on the first en=1 cycle.
- Latency: done is first seen high after DATA_W+2 rising edges with en=1, counting the LOAD edge.
- Width rule: the addend is initialised at weight 2^DATA_W and shifted down to weight 1. The maximum (2^N-1)^2 + (2^N-1) = 2^2N - 2^N fits in 2N bits, so no overflow. The hi carry bit is always 0 after each shift.
- Operand stability: inputs are sampled only at LOAD. Changes to them during STEP or DONE have no effect.
- Dropping en mid-operation aborts and clears on the next edge. No partial result is exposed, because done stays 0.
- en rising at the same edge that rst deasserts: rst dominates while asserted. The first en edge after release is LOAD.
- Zero operands: the loop still runs the full DATA_W steps. Latency is data-independent.

Optional Feature:
MUL_SHIFTADD_SIGNED_EN
- Defined: operands are two's complement.
  - LOAD stores |multiplicand| and |multiplier| (|-2^(N-1)| = 2^(N-1), held unsigned in N bits).
  - LOAD records neg = sign(A) XOR sign(B), and sets hi <= 0.
  - The STEP loop is unchanged.
  - At pc=DATA_W+1: product <= (neg ? -P : P) + sign_extend(addend) in 2*DATA_W bits, and done <= 1 on the same edge. Latency is unchanged.
- Undefined: unsigned behaviour exactly as above, with no sign logic synthesised.

Test Plan:
- DATA_W=8, A=0x0D, B=0x0B, C=0x05, en held -> done rises after 10 edges; product=0x0094 (148); product stays stable while en=1.
- DATA_W=8, A=0xFF, B=0xFF, C=0xFF -> product=0xFF00 (max case, no overflow); DATA_W=32, A=B=C=0xFFFFFFFF -> 0xFFFFFFFF00000000.
- Divider inverse, DATA_W=32: A=quotient 0x00000007, B=divisor 0x00000009, C=remainder 0x00000004 -> product=0x000000000000043 (67 = the original dividend).
- Abort and restart: en high 5 cycles, then low 1 cycle, then A=3, B=4, C=0 -> done=0 during the low cycle; product=12 after 10 further edges; no stale data.
- Async rst pulsed mid-STEP (between clock edges) -> done=0 and product=0 immediately, before the next edge; the next en run completes normally.
- With MUL_SHIFTADD_SIGNED_EN, DATA_W=8: A=0x80 (-128), B=0x80, C=0x01 -> product=0x4001. A=0xFD (-3), B=0x05, C=0xFE (-2) -> product=0xFFEF (-17).
